// File: rtl/clk_ctrl_pkg.sv
// Shared types and constants for the timekeeping / set-mode controller.
package clk_ctrl_pkg;

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    SET_HR  = 3'd1,
    SET_MIN = 3'd2,
    SET_SEC = 3'd3,
    SET_AH  = 3'd4,
    SET_AM  = 3'd5
  } state_t;

  localparam logic [5:0] HR_MAX  = 6'd23;
  localparam logic [5:0] MIN_MAX = 6'd59;
  localparam logic [5:0] SEC_MAX = 6'd59;

  localparam logic [1:0] FS_NONE = 2'd0;
  localparam logic [1:0] FS_HR   = 2'd1;
  localparam logic [1:0] FS_MIN  = 2'd2;
  localparam logic [1:0] FS_SEC  = 2'd3;

  // Increment with wrap at max; fields are never allowed outside 0..max.
  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max);
    return (v == max) ? 6'd0 : v + 6'd1;
  endfunction

endpackage

// File: rtl/time_set_ctrl_tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV enabled cycles; cleared whenever disabled.
module tick_gen #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = en && (count == LAST);

endmodule

// File: rtl/time_set_ctrl.sv
// Timekeeping and set-mode controller: h/m/s counters, edit FSM, optional alarm.
// Optional alarm feature is enabled by defining ALARM_EN.
module time_set_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic [5:0] outh,
  output logic [5:0] outm,
  output logic [5:0] outs,
  output logic [1:0] field_sel,
  output logic       sec_pulse,
  input  logic       alarm_on,
  input  logic       alarm_ack,
  output logic       alarm
);

  state_t state, state_d;
  logic   tick;
  logic   inc_eff;

  // A simultaneous mode press takes priority and swallows the increment.
  assign inc_eff = inc_btn && !mode_btn;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .en    (state == RUN),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d   = state;
    field_sel = FS_NONE;
    case (state)
      RUN: begin
        if (mode_btn) state_d = SET_HR;
      end
      SET_HR: begin
        field_sel = FS_HR;
        if (mode_btn) state_d = SET_MIN;
      end
      SET_MIN: begin
        field_sel = FS_MIN;
        if (mode_btn) state_d = SET_SEC;
      end
      SET_SEC: begin
        field_sel = FS_SEC;
`ifdef ALARM_EN
        if (mode_btn) state_d = SET_AH;
`else
        if (mode_btn) state_d = RUN;
`endif
      end
      SET_AH: begin
        field_sel = FS_HR;
        if (mode_btn) state_d = SET_AM;
      end
      SET_AM: begin
        field_sel = FS_MIN;
        if (mode_btn) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Time fields: carry chain on a RUN tick, single-field wrap-only edits in SET states.
  always_ff @(posedge clk) begin
    if (reset) begin
      outh      <= 6'd0;
      outm      <= 6'd0;
      outs      <= 6'd0;
      sec_pulse <= 1'b0;
    end else begin
      sec_pulse <= tick;
      case (state)
        RUN: begin
          if (tick) begin
            outs <= wrap_inc(outs, SEC_MAX);
            if (outs == SEC_MAX) begin
              outm <= wrap_inc(outm, MIN_MAX);
              if (outm == MIN_MAX) outh <= wrap_inc(outh, HR_MAX);
            end
          end
        end
        SET_HR:  if (inc_eff) outh <= wrap_inc(outh, HR_MAX);
        SET_MIN: if (inc_eff) outm <= wrap_inc(outm, MIN_MAX);
        SET_SEC: if (inc_eff) outs <= wrap_inc(outs, SEC_MAX);
        default: ;
      endcase
    end
  end

`ifdef ALARM_EN
  logic [5:0] alarm_hr;
  logic [5:0] alarm_min;
  logic       silenced;
  logic       min_change;

  assign min_change = ((state == RUN) && tick && (outs == SEC_MAX)) ||
                      ((state == SET_MIN) && inc_eff);

  // Alarm setpoint edits plus the acknowledge latch, which releases on the next minute change.
  always_ff @(posedge clk) begin
    if (reset) begin
      alarm_hr  <= 6'd0;
      alarm_min <= 6'd0;
      silenced  <= 1'b0;
    end else begin
      if ((state == SET_AH) && inc_eff) alarm_hr  <= wrap_inc(alarm_hr, HR_MAX);
      if ((state == SET_AM) && inc_eff) alarm_min <= wrap_inc(alarm_min, MIN_MAX);
      if (min_change) begin
        silenced <= 1'b0;
      end else if (alarm_ack) begin
        silenced <= 1'b1;
      end
    end
  end

  assign alarm = (state == RUN) && alarm_on && (outh == alarm_hr) &&
                 (outm == alarm_min) && !silenced;
`else
  logic unused_alarm_in;
  assign unused_alarm_in = alarm_on | alarm_ack;
  assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed testbench for time_set_ctrl with TICK_DIV=4; alarm scenario built only with ALARM_EN.
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       mode_btn;
  logic       inc_btn;
  logic [5:0] outh, outm, outs;
  logic [1:0] field_sel;
  logic       sec_pulse;
  logic       alarm_on;
  logic       alarm_ack;
  logic       alarm;

  int checks   = 0;
  int failures = 0;

  time_set_ctrl #(.TICK_DIV(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode_btn  (mode_btn),
    .inc_btn   (inc_btn),
    .outh      (outh),
    .outm      (outm),
    .outs      (outs),
    .field_sel (field_sel),
    .sec_pulse (sec_pulse),
    .alarm_on  (alarm_on),
    .alarm_ack (alarm_ack),
    .alarm     (alarm)
  );

  always #5 clk = ~clk;

  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic m, input logic i);
    mode_btn = m;
    inc_btn  = i;
    cycle(1);
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    cycle(2);
    reset = 1'b0;
  endtask

  // Leaves the DUT in SET_SEC holding h:m:s.
  task automatic set_time(input int h, input int m, input int s);
    do_reset();
    press(1'b1, 1'b0);
    repeat (h) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    repeat (m) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    repeat (s) press(1'b0, 1'b1);
  endtask

  task automatic to_run;
`ifdef ALARM_EN
    repeat (3) press(1'b1, 1'b0);
`else
    press(1'b1, 1'b0);
`endif
  endtask

  task automatic test_reset;
    reset = 1'b1;
    cycle(2);
    checks++;
    if ({outh, outm, outs} !== {6'd0, 6'd0, 6'd0}) begin
      failures++; $display("FAIL reset_time got=%0d:%0d:%0d exp=0:0:0", outh, outm, outs);
    end
    checks++;
    if (field_sel !== 2'd0) begin
      failures++; $display("FAIL reset_field_sel got=%0d exp=0", field_sel);
    end
    checks++;
    if (sec_pulse !== 1'b0 || alarm !== 1'b0) begin
      failures++; $display("FAIL reset_outputs got sec_pulse=%0b alarm=%0b exp=0/0", sec_pulse, alarm);
    end
    reset = 1'b0;
  endtask

  task automatic test_run_tick;
    do_reset();
    cycle(3);
    checks++;
    if (outs !== 6'd0 || sec_pulse !== 1'b0) begin
      failures++; $display("FAIL run_pretick got outs=%0d pulse=%0b exp=0/0", outs, sec_pulse);
    end
    cycle(1);
    checks++;
    if (outs !== 6'd1 || sec_pulse !== 1'b1) begin
      failures++; $display("FAIL run_first_tick got outs=%0d pulse=%0b exp=1/1", outs, sec_pulse);
    end
    cycle(1);
    checks++;
    if (outs !== 6'd1 || sec_pulse !== 1'b0) begin
      failures++; $display("FAIL run_pulse_width got outs=%0d pulse=%0b exp=1/0", outs, sec_pulse);
    end
    cycle(235);
    checks++;
    if ({outh, outm, outs} !== {6'd0, 6'd1, 6'd0} || sec_pulse !== 1'b1) begin
      failures++; $display("FAIL run_minute got=%0d:%0d:%0d pulse=%0b exp=0:1:0/1", outh, outm, outs, sec_pulse);
    end
  endtask

  task automatic test_inc_in_run;
    do_reset();
    press(1'b0, 1'b1);
    checks++;
    if ({outh, outm, outs} !== {6'd0, 6'd0, 6'd0} || field_sel !== 2'd0) begin
      failures++; $display("FAIL inc_in_run got=%0d:%0d:%0d fs=%0d exp=0:0:0 fs=0", outh, outm, outs, field_sel);
    end
  endtask

  task automatic test_rollover;
    set_time(23, 59, 59);
    checks++;
    if ({outh, outm, outs} !== {6'd23, 6'd59, 6'd59} || field_sel !== 2'd3) begin
      failures++; $display("FAIL preload got=%0d:%0d:%0d fs=%0d exp=23:59:59 fs=3", outh, outm, outs, field_sel);
    end
    to_run();
    checks++;
    if (field_sel !== 2'd0) begin
      failures++; $display("FAIL rollover_run_fs got=%0d exp=0", field_sel);
    end
    cycle(3);
    checks++;
    if ({outh, outm, outs} !== {6'd23, 6'd59, 6'd59} || sec_pulse !== 1'b0) begin
      failures++; $display("FAIL rollover_restart got=%0d:%0d:%0d pulse=%0b exp=23:59:59/0", outh, outm, outs, sec_pulse);
    end
    cycle(1);
    checks++;
    if ({outh, outm, outs} !== {6'd0, 6'd0, 6'd0} || sec_pulse !== 1'b1) begin
      failures++; $display("FAIL rollover_wrap got=%0d:%0d:%0d pulse=%0b exp=0:0:0/1", outh, outm, outs, sec_pulse);
    end
    cycle(1);
    checks++;
    if (sec_pulse !== 1'b0) begin
      failures++; $display("FAIL rollover_single_pulse got=%0b exp=0", sec_pulse);
    end
  endtask

  task automatic test_set_hr;
    logic pulse_seen;
    do_reset();
    press(1'b1, 1'b0);
    checks++;
    if (field_sel !== 2'd1) begin
      failures++; $display("FAIL set_hr_fs got=%0d exp=1", field_sel);
    end
    repeat (25) press(1'b0, 1'b1);
    checks++;
    if ({outh, outm, outs} !== {6'd1, 6'd0, 6'd0}) begin
      failures++; $display("FAIL set_hr_wrap got=%0d:%0d:%0d exp=1:0:0", outh, outm, outs);
    end
    pulse_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cycle(1);
      if (sec_pulse) pulse_seen = 1'b1;
    end
    checks++;
    if ({outh, outm, outs} !== {6'd1, 6'd0, 6'd0} || pulse_seen !== 1'b0) begin
      failures++; $display("FAIL set_frozen got=%0d:%0d:%0d pulse_seen=%0b exp=1:0:0/0", outh, outm, outs, pulse_seen);
    end
  endtask

  task automatic test_mode_inc_same;
    do_reset();
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    repeat (3) press(1'b0, 1'b1);
    checks++;
    if (outm !== 6'd3 || field_sel !== 2'd2) begin
      failures++; $display("FAIL set_min got outm=%0d fs=%0d exp=3/2", outm, field_sel);
    end
    press(1'b1, 1'b1);
    checks++;
    if (field_sel !== 2'd3 || outm !== 6'd3 || outs !== 6'd0) begin
      failures++; $display("FAIL mode_wins got fs=%0d outm=%0d outs=%0d exp=3/3/0", field_sel, outm, outs);
    end
    press(1'b0, 1'b1);
    checks++;
    if (outs !== 6'd1 || outm !== 6'd3) begin
      failures++; $display("FAIL set_sec_inc got outs=%0d outm=%0d exp=1/3", outs, outm);
    end
  endtask

  task automatic test_field_wrap;
    set_time(0, 59, 59);
    press(1'b0, 1'b1);
    checks++;
    if ({outh, outm, outs} !== {6'd0, 6'd59, 6'd0}) begin
      failures++; $display("FAIL sec_wrap_no_carry got=%0d:%0d:%0d exp=0:59:0", outh, outm, outs);
    end
  endtask

  task automatic test_reset_mid_edit;
    set_time(12, 34, 56);
    checks++;
    if ({outh, outm, outs} !== {6'd12, 6'd34, 6'd56} || field_sel !== 2'd3) begin
      failures++; $display("FAIL mid_edit_preload got=%0d:%0d:%0d fs=%0d exp=12:34:56 fs=3", outh, outm, outs, field_sel);
    end
    reset = 1'b1;
    cycle(1);
    checks++;
    if ({outh, outm, outs} !== {6'd0, 6'd0, 6'd0} || field_sel !== 2'd0) begin
      failures++; $display("FAIL mid_edit_reset got=%0d:%0d:%0d fs=%0d exp=0:0:0 fs=0", outh, outm, outs, field_sel);
    end
    reset = 1'b0;
    cycle(4);
    checks++;
    if (outs !== 6'd1) begin
      failures++; $display("FAIL mid_edit_runs got outs=%0d exp=1", outs);
    end
  endtask

`ifdef ALARM_EN
  task automatic test_alarm;
    logic alarm_seen;
    do_reset();
    repeat (4) press(1'b1, 1'b0);
    checks++;
    if (field_sel !== 2'd1) begin
      failures++; $display("FAIL set_ah_fs got=%0d exp=1", field_sel);
    end
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    checks++;
    if (field_sel !== 2'd2 || {outh, outm, outs} !== {6'd0, 6'd0, 6'd0}) begin
      failures++; $display("FAIL set_am got fs=%0d time=%0d:%0d:%0d exp=2 0:0:0", field_sel, outh, outm, outs);
    end
    alarm_on = 1'b1;
    press(1'b1, 1'b0);
    cycle(239);
    checks++;
    if (alarm !== 1'b0 || {outh, outm, outs} !== {6'd0, 6'd0, 6'd59}) begin
      failures++; $display("FAIL alarm_early got alarm=%0b time=%0d:%0d:%0d exp=0 0:0:59", alarm, outh, outm, outs);
    end
    cycle(1);
    checks++;
    if (alarm !== 1'b1 || {outh, outm, outs} !== {6'd0, 6'd1, 6'd0}) begin
      failures++; $display("FAIL alarm_fire got alarm=%0b time=%0d:%0d:%0d exp=1 0:1:0", alarm, outh, outm, outs);
    end
    alarm_ack = 1'b1;
    cycle(1);
    alarm_ack = 1'b0;
    checks++;
    if (alarm !== 1'b0) begin
      failures++; $display("FAIL alarm_ack got=%0b exp=0", alarm);
    end
    alarm_seen = 1'b0;
    for (int i = 0; i < 238; i++) begin
      cycle(1);
      if (alarm) alarm_seen = 1'b1;
    end
    cycle(1);
    checks++;
    if (alarm_seen !== 1'b0 || alarm !== 1'b0 || {outh, outm, outs} !== {6'd0, 6'd2, 6'd0}) begin
      failures++; $display("FAIL alarm_silenced got seen=%0b alarm=%0b time=%0d:%0d:%0d exp=0/0 0:2:0", alarm_seen, alarm, outh, outm, outs);
    end
    alarm_on = 1'b0;
  endtask
`endif

  initial begin
    reset     = 1'b1;
    mode_btn  = 1'b0;
    inc_btn   = 1'b0;
    alarm_on  = 1'b0;
    alarm_ack = 1'b0;
    test_reset();
    test_run_tick();
    test_inc_in_run();
    test_rollover();
    test_set_hr();
    test_mode_inc_same();
    test_field_wrap();
    test_reset_mid_edit();
`ifdef ALARM_EN
    test_alarm();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
